// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Front-panel controller for the StopWatch counter datapath.
//            Two raw push-buttons are synchronized, optionally debounced and
//            edge-detected into single-cycle events. These events drive a
//            four-state mode machine (IDLE/RUN/PAUSE/LAP). A lap-hold
//            register freezes the displayed digits while counting continues.
// Config   : `STOPWATCH_DEBOUNCE_EN -- when defined, each button gets a
//            counter debouncer requiring DEBOUNCE_CYCLES stable cycles.
//            When undefined, the synchronizer output is used directly and
//            DEBOUNCE_CYCLES has no effect.
// Ports    :
//   clk                              in   system clock, rising edge
//   reset                            in   asynchronous reset, active-low
//   btn_ss, btn_lap                  in   raw buttons, active-high, async
//   min0, sec1, sec0, milSec0        in   live BCD digits from StopWatch
//   start_resume                     out  1 = StopWatch counts
//   stop                             out  always ~start_resume
//   sw_reset                         out  active-high clear to StopWatch
//   disp_min0..disp_milSec0          out  digits to display
//   lap_active                       out  1 while held lap values are shown
//   state                            out  IDLE=00 RUN=01 PAUSE=10 LAP=11
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic [3:0] min0,
  input  logic [3:0] sec1,
  input  logic [3:0] sec0,
  input  logic [3:0] milSec0,
  output logic       start_resume,
  output logic       stop,
  output logic       sw_reset,
  output logic [3:0] disp_min0,
  output logic [3:0] disp_sec1,
  output logic [3:0] disp_sec0,
  output logic [3:0] disp_milSec0,
  output logic       lap_active,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_t;

  // Bit 0 = start/stop button, bit 1 = lap/clear button.
  logic [1:0] btn_raw;
  logic [1:0] ev;
  logic       ss_ev;
  logic       lap_ev;

  assign btn_raw = {btn_lap, btn_ss};
  assign ss_ev   = ev[0];
  assign lap_ev  = ev[1];

  // Marks when the synchronizer stages hold samples taken after reset
  // release. Until then their zeros are reset values, not observed levels.
  logic [1:0] sync_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_valid <= 2'b00;
    end else begin
      sync_valid <= {sync_valid[0], 1'b1};
    end
  end

  // --------------------------------------------------------------------------
  // Button conditioning: synchronizer, debouncer, rising-edge detector
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic sync1;
    logic sync2;
    logic db;
    logic db_q;
    logic armed;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        db_q  <= 1'b0;
      end else begin
        sync1 <= btn_raw[i];
        sync2 <= sync1;
        db_q  <= db;
      end
    end

    // A button already held when reset is released must not fire. Events
    // are only enabled once the button has been observed released after
    // reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        armed <= 1'b0;
      end else if (sync_valid[1] && !sync2) begin
        armed <= 1'b1;
      end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count consecutive cycles where the synchronized level disagrees with
    // the accepted level; any agreement restarts the count.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
        db  <= 1'b0;
      end else if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
`else
    assign db = sync2;
`endif

    assign ev[i] = armed & db & ~db_q;
  end

  // --------------------------------------------------------------------------
  // Mode machine
  // --------------------------------------------------------------------------
  state_t cur_state;
  state_t nxt_state;
  logic   lap_capture;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Start/stop always takes priority over lap/clear in the same cycle.
  always_comb begin
    nxt_state   = cur_state;
    lap_capture = 1'b0;
    case (cur_state)
      ST_IDLE: begin
        if (ss_ev) begin
          nxt_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ss_ev) begin
          nxt_state = ST_PAUSE;
        end else if (lap_ev) begin
          nxt_state   = ST_LAP;
          lap_capture = 1'b1;
        end
      end
      ST_LAP: begin
        if (ss_ev) begin
          nxt_state = ST_PAUSE;
        end else if (lap_ev) begin
          nxt_state = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (ss_ev) begin
          nxt_state = ST_RUN;
        end else if (lap_ev) begin
          nxt_state = ST_IDLE;
        end
      end
      default: begin
        nxt_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Lap-hold registers, loaded only on the edge that enters LAP
  // --------------------------------------------------------------------------
  logic [15:0] lap_digits;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_digits <= '0;
    end else if (lap_capture) begin
      lap_digits <= {min0, sec1, sec0, milSec0};
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. The encoding makes start_resume and stop direct copies of a
  // state flop bit, so the StopWatch controls cannot glitch.
  // --------------------------------------------------------------------------
  assign state        = cur_state;
  assign start_resume = cur_state[0];
  assign stop         = ~cur_state[0];
  assign sw_reset     = (cur_state == ST_IDLE);
  assign lap_active   = (cur_state == ST_LAP);

  assign {disp_min0, disp_sec1, disp_sec0, disp_milSec0} =
    lap_active ? lap_digits : {min0, sec1, sec0, milSec0};

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Purpose  : Scoreboard bench for stopwatch_ctrl. Stimulus pushes the
//            expected state transition (state, decoded outputs, display,
//            edge number) into a queue; a monitor pops and compares each
//            time the DUT state changes. Expected latency follows
//            `STOPWATCH_DEBOUNCE_EN (DEBOUNCE_CYCLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int DBC = 4;
`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int LAT = 2 + DBC;
`else
  localparam int LAT = 2;
`endif

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic        btn_ss  = 1'b0;
  logic        btn_lap = 1'b0;
  logic [15:0] live    = 16'h0000;

  wire [3:0] min0    = live[15:12];
  wire [3:0] sec1    = live[11:8];
  wire [3:0] sec0    = live[7:4];
  wire [3:0] milSec0 = live[3:0];

  wire       start_resume;
  wire       stop;
  wire       sw_reset;
  wire [3:0] disp_min0;
  wire [3:0] disp_sec1;
  wire [3:0] disp_sec0;
  wire [3:0] disp_milSec0;
  wire       lap_active;
  wire [1:0] state;
  wire [15:0] disp = {disp_min0, disp_sec1, disp_sec0, disp_milSec0};

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DBC)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_ss       (btn_ss),
    .btn_lap      (btn_lap),
    .min0         (min0),
    .sec1         (sec1),
    .sec0         (sec0),
    .milSec0      (milSec0),
    .start_resume (start_resume),
    .stop         (stop),
    .sw_reset     (sw_reset),
    .disp_min0    (disp_min0),
    .disp_sec1    (disp_sec1),
    .disp_sec0    (disp_sec0),
    .disp_milSec0 (disp_milSec0),
    .lap_active   (lap_active),
    .state        (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  st;
    logic [15:0] disp;
    int          at;   // expected edge number, -1 = asynchronous
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  logic [1:0] prev_st = 2'b00;

  function automatic void push(input logic [1:0] st, input logic [15:0] d,
                               input int at);
    exp_t e;
    e.st   = st;
    e.disp = d;
    e.at   = at;
    q.push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drained(input string nm);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected transitions never seen (want 0)",
               nm, q.size());
      q.delete();
    end
  endtask

  // Drive buttons for 'hold' sampling edges, release, let debounce settle.
  task automatic press(input string nm, input bit ss, input bit lp,
                       input int hold, input bit exp_tr,
                       input logic [1:0] st, input logic [15:0] d);
    int e0;
    @(negedge clk);
    e0 = cyc + 1;
    if (exp_tr) push(st, d, e0 + LAT);
    btn_ss  = ss;
    btn_lap = lp;
    repeat (hold) @(negedge clk);
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    repeat (14) @(negedge clk);
    drained(nm);
  endtask

  // Monitor: every state change is a DUT output event to be scored.
  initial begin
    exp_t       e;
    logic [3:0] want_ctl;
    logic [3:0] got_ctl;
    logic       run_like;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (state !== prev_st) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_transition: state %b -> %b at edge %0d, want no change",
                     prev_st, state, cyc);
          end else begin
            e        = q.pop_front();
            run_like = (e.st == S_RUN) || (e.st == S_LAP);
            want_ctl = {run_like, ~run_like, e.st == S_IDLE, e.st == S_LAP};
            got_ctl  = {start_resume, stop, sw_reset, lap_active};
            if (state !== e.st || got_ctl !== want_ctl || disp !== e.disp ||
                (e.at >= 0 && cyc != e.at)) begin
              bad++;
              $display("FAIL transition: got state=%b ctl=%b disp=%h edge=%0d want state=%b ctl=%b disp=%h edge=%0d",
                       state, got_ctl, disp, cyc, e.st, want_ctl, e.disp, e.at);
            end
          end
        end
        prev_st = state;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, want finish");
    $fatal(1);
  end

  initial begin
    // ---- Scenario 1: reset values, first start ----
    live = 16'h9876;
    repeat (2) @(negedge clk);
    chk("in_reset_state", {30'd0, state}, {30'd0, S_IDLE});
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_state",        {30'd0, state}, {30'd0, S_IDLE});
    chk("rst_sw_reset",     {31'd0, sw_reset}, 32'd1);
    chk("rst_start_resume", {31'd0, start_resume}, 32'd0);
    chk("rst_stop",         {31'd0, stop}, 32'd1);
    chk("rst_lap_active",   {31'd0, lap_active}, 32'd0);
    chk("rst_disp_live",    {16'd0, disp}, 32'h9876);
    prev_st = state;
    mon_en  = 1'b1;
    live    = 16'h1234;
    repeat (3) @(negedge clk);
    chk("disp_follows_live", {16'd0, disp}, 32'h1234);
    press("s1_start", 1'b1, 1'b0, 10, 1'b1, S_RUN, 16'h1234);

    // ---- Scenario 2: lap hold and release ----
    press("s2_lap_in", 1'b0, 1'b1, 10, 1'b1, S_LAP, 16'h1234);
    live = 16'h1250;
    @(negedge clk);
    chk("lap_hold_disp",     {16'd0, disp}, 32'h1234);
    chk("lap_still_counts",  {31'd0, start_resume}, 32'd1);
    press("s2_lap_out", 1'b0, 1'b1, 10, 1'b1, S_RUN, 16'h1250);

    // ---- Scenario 3: pause / resume / clear ----
    press("s3_pause",  1'b1, 1'b0, 10, 1'b1, S_PAUSE, 16'h1250);
    press("s3_resume", 1'b1, 1'b0, 10, 1'b1, S_RUN,   16'h1250);
    press("s3_pause2", 1'b1, 1'b0, 10, 1'b1, S_PAUSE, 16'h1250);
    press("s3_clear",  1'b0, 1'b1, 10, 1'b1, S_IDLE,  16'h1250);

    // ---- Scenario 4: 3-cycle glitch in IDLE ----
    press("s4_glitch", 1'b1, 1'b0, 3, LAT == 2, S_RUN, 16'h1250);
    chk("glitch_state", {30'd0, state}, {30'd0, (LAT == 2) ? S_RUN : S_IDLE});
    // Return to IDLE through reset regardless of build.
    if (LAT == 2) push(S_IDLE, 16'h1250, -1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    drained("s4_normalise");

    // ---- Scenario 5: simultaneous buttons in RUN ----
    press("s5_start", 1'b1, 1'b0, 10, 1'b1, S_RUN,   16'h1250);
    press("s5_both",  1'b1, 1'b1, 10, 1'b1, S_PAUSE, 16'h1250);
    chk("both_no_lap", {31'd0, lap_active}, 32'd0);
    press("s5_clear", 1'b0, 1'b1, 10, 1'b1, S_IDLE,  16'h1250);

    // ---- Scenario 6: long hold, reset during LAP, held across reset ----
    press("s6_long_hold", 1'b1, 1'b0, 40, 1'b1, S_RUN, 16'h1250);
    live = 16'h0359;
    press("s6_lap_in", 1'b0, 1'b1, 10, 1'b1, S_LAP, 16'h0359);
    live = 16'h0400;
    @(negedge clk);
    btn_ss = 1'b1;
    push(S_IDLE, 16'h0400, -1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_state",    {30'd0, state}, {30'd0, S_IDLE});
    chk("async_rst_lap",      {31'd0, lap_active}, 32'd0);
    chk("async_rst_sw_reset", {31'd0, sw_reset}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("held_across_reset", {30'd0, state}, {30'd0, S_IDLE});
    btn_ss = 1'b0;
    repeat (14) @(negedge clk);
    drained("s6_reset");
    press("s6_repress", 1'b1, 1'b0, 10, 1'b1, S_RUN, 16'h0400);

    drained("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-panel controller for the StopWatch counter datapath. It turns two raw push-buttons into clean single-cycle events and runs a four-state mode machine. The machine drives StopWatch's `start_resume`, `stop` and `reset` inputs. A lap-hold register freezes the displayed digits while counting continues. The block sits between the board buttons and the StopWatch instance; its display outputs feed the digit decoders.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized cycles required before a button level is accepted.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears every register below.
- `btn_ss` in 1: raw start/stop button, active-high, asynchronous to `clk`.
- `btn_lap` in 1: raw lap/clear button, active-high, asynchronous.
- `min0`, `sec1`, `sec0`, `milSec0` in 4 each: live BCD digits from StopWatch.
- `start_resume` out 1: to StopWatch; 1 = count.
- `stop` out 1: to StopWatch; always `~start_resume`.
- `sw_reset` out 1: to StopWatch `reset`, active-high; holds the counter cleared.
- `disp_min0`, `disp_sec1`, `disp_sec0`, `disp_milSec0` out 4 each: digits to display.
- `lap_active` out 1: 1 while the display shows held lap values.
- `state` out 2: IDLE=00, RUN=01, PAUSE=10, LAP=11.

## Operation
- **Button path (per button):**
  - 2-FF synchronizer.
  - Debouncer: see Configuration.
  - Rising-edge detect `ev = db & ~db_q`, a one-cycle pulse.
  - Releases generate nothing.
  - Holding a button produces exactly one event.
- **FSM (registered, updates on the edge where `ev` is high):**
  - IDLE: `ss_ev` goes to RUN. `lap_ev` is ignored.
  - RUN: `ss_ev` goes to PAUSE. `lap_ev` goes to LAP and captures the four live digits into the lap registers on the same edge.
  - LAP: counting continues. `lap_ev` goes to RUN and releases the hold. `ss_ev` goes to PAUSE and releases the hold.
  - PAUSE: `ss_ev` goes to RUN (resume, no clear). `lap_ev` goes to IDLE, which clears the count.
  - If `ss_ev` and `lap_ev` occur in the same cycle, `ss_ev` wins and `lap_ev` is dropped.
- **Outputs, decoded from the state register (glitch-free):**
  - `start_resume` = 1 in RUN or LAP.
  - `sw_reset` = 1 in IDLE only.
  - `lap_active` = 1 in LAP only.
  - `disp_*` = lap registers when `lap_active`, otherwise the live digits (combinational mux).
- **Lap registers:** written only on entry to LAP. Their contents are don't-care when not displayed.
- **Reset values:**
  - `state` = IDLE, so `sw_reset` = 1, `start_resume` = 0, `stop` = 1, `lap_active` = 0.
  - Lap registers = 0; synchronizers, debouncers and `db_q` = 0.
  - `disp_*` follow the live inputs.
- **Reset asserted mid-operation:** everything returns to IDLE immediately (asynchronously). A button still held at reset release does not generate an event until it has been released and pressed again.

## Timing
- Let edge 0 be the first `clk` edge that samples a raw press high.
- Synchronizer output rises at edge 1.
- With debounce compiled in, `db` rises at edge 1+`DEBOUNCE_CYCLES`. `ev` is high during the following cycle. `state` and all outputs change at edge 2+`DEBOUNCE_CYCLES`.
- With debounce compiled out, `state` changes at edge 2.
- Lap capture samples the digit inputs at the same edge the state enters LAP, so the displayed value equals the live digits of the preceding cycle.
- StopWatch sees each new control level one register stage after the event; there is no combinational path from the buttons to the outputs.

## Configuration
- Macro: `STOPWATCH_DEBOUNCE_EN`.
- Defined:
  - The debouncer is a counter per button, `$clog2(DEBOUNCE_CYCLES)+1` bits wide.
  - The counter increments while the synchronized input differs from `db`, and clears when they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 and the inputs still differ, `db` takes the synchronized value and the counter clears.
  - Pulses shorter than `DEBOUNCE_CYCLES` cycles are rejected.
- Undefined: `db` is the synchronizer output directly, the counters are absent, and `DEBOUNCE_CYCLES` is unused.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4 with the macro defined; the no-debounce build reruns scenarios 1 and 4.

1. Reset low for 5 cycles, then high → `state`=00, `sw_reset`=1, `start_resume`=0, `stop`=1, `lap_active`=0. Press `btn_ss` for 10 cycles → `state`=01 and `start_resume`=1 exactly at edge 6 after the press is first sampled (edge 2 in the no-debounce build).
2. From RUN with live digits 1,2,3,4: press lap → `state`=11, `disp_*`=1,2,3,4. Then change live digits to 1,2,5,0 → `disp_*` stay 1,2,3,4. Press lap again → `state`=01 and `disp_*` show 1,2,5,0.
3. RUN, press ss → PAUSE (`stop`=1, `sw_reset`=0). Press ss → RUN. Press ss → PAUSE. Press lap → IDLE with `sw_reset`=1.
4. Raw `btn_ss` glitch 3 cycles high while in IDLE → no state change with debounce compiled in; RUN in the no-debounce build.
5. Both buttons rise on the same cycle while in RUN → PAUSE, no lap capture, `lap_active`=0.
6. Hold `btn_ss` high for 40 cycles → exactly one transition. Assert reset during LAP → immediate IDLE, `lap_active`=0. With the button still held across reset release → state stays IDLE.
